// File: rtl/bcd_counter_display.sv
// bcd_counter_display: prescaled N-digit BCD up/down counter with registered 7-segment decode.
// Define BCD_LEADING_BLANK_EN to blank leading-zero digits (digit 0 is never blanked).
module bcd_counter_display #(
  parameter int DIGITS = 4,
  parameter int DIV = 50_000_000,
  parameter bit SEG_ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst_a,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  tick,
  output logic                  tc,
  output logic [7*DIGITS-1:0]   segs
);
  localparam int PW = DIV > 1 ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);
  logic [PW-1:0] pre_q, pre_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic tick_q, tick_d, tc_q, tc_d;
  logic [7*DIGITS-1:0] segs_q, segs_d;
  logic [4*DIGITS:0] nxt;
  logic step;
  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0: glyph = 7'h3F;
      4'd1: glyph = 7'h06;
      4'd2: glyph = 7'h5B;
      4'd3: glyph = 7'h4F;
      4'd4: glyph = 7'h66;
      4'd5: glyph = 7'h6D;
      4'd6: glyph = 7'h7D;
      4'd7: glyph = 7'h07;
      4'd8: glyph = 7'h7F;
      default: glyph = 7'h6F;
    endcase
  endfunction
  function automatic logic [4*DIGITS-1:0] clamp(input logic [4*DIGITS-1:0] v);
    for (int k = 0; k < DIGITS; k++)
      clamp[4*k+:4] = v[4*k+:4] > 4'd9 ? 4'd9 : v[4*k+:4];
  endfunction
  // Ripple step across all digits; top bit is the carry/borrow out, i.e. wrap.
  function automatic logic [4*DIGITS:0] advance(input logic [4*DIGITS-1:0] v, input logic dir);
    logic c;
    logic [3:0] d;
    c = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      d = v[4*k+:4];
      advance[4*k+:4] = !c ? d : dir ? (d == 4'd9 ? 4'd0 : d + 4'd1) : (d == 4'd0 ? 4'd9 : d - 4'd1);
      c = c && d == (dir ? 4'd9 : 4'd0);
    end
    advance[4*DIGITS] = c;
  endfunction
  function automatic logic [7*DIGITS-1:0] decode(input logic [4*DIGITS-1:0] v);
`ifdef BCD_LEADING_BLANK_EN
    logic lead;
    lead = 1'b1;
`endif
    for (int k = DIGITS - 1; k >= 0; k--) begin
`ifdef BCD_LEADING_BLANK_EN
      lead = lead && v[4*k+:4] == 4'd0;
      decode[7*k+:7] = (lead && k != 0) ? (SEG_ACTIVE_LOW ? 7'h7F : 7'h00)
                     : SEG_ACTIVE_LOW ? ~glyph(v[4*k+:4]) : glyph(v[4*k+:4]);
`else
      decode[7*k+:7] = SEG_ACTIVE_LOW ? ~glyph(v[4*k+:4]) : glyph(v[4*k+:4]);
`endif
    end
  endfunction
  always_comb begin
    step = en && !load && pre_q == PMAX;
    nxt = advance(bcd_q, up);
    pre_d = (load || step) ? '0 : en ? pre_q + 1'b1 : pre_q;
    bcd_d = load ? clamp(load_val) : step ? nxt[4*DIGITS-1:0] : bcd_q;
    tick_d = step;
    tc_d = step && nxt[4*DIGITS];
    segs_d = decode(bcd_q);
  end
  always_ff @(posedge clk) begin
    if (rst_a) begin
      pre_q <= '0;
      bcd_q <= '0;
      tick_q <= 1'b0;
      tc_q <= 1'b0;
      segs_q <= decode('0);
    end else begin
      pre_q <= pre_d;
      bcd_q <= bcd_d;
      tick_q <= tick_d;
      tc_q <= tc_d;
      segs_q <= segs_d;
    end
  end
  assign bcd = bcd_q;
  assign tick = tick_q;
  assign tc = tc_q;
  assign segs = segs_q;
endmodule
